board_game_ctrl: RTL

- Clocked two-player board controller: holds both player positions on a 2^POS_W-cell track, sequences turns and step sizes, applies move requests, blocks collisions, detects the winner.
- Drives the one-hot LED track and status outputs.
- Replaces the free-running, unclocked position/turn logic with one synchronous FSM, parametrised in board size and step profile.

---
 rtl/board_pkg.sv | 22 ++
 rtl/board_game_ctrl_if.sv | 35 +++
 rtl/board_game_ctrl_step_seq.sv | 52 +++++
 rtl/board_game_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types for the two-player board controller: FSM states, player and
// direction encodings.
package board_pkg;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_MOVE = 2'd1,
        S_OVER = 2'd2
    } state_e;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_e;

    // Advance means towards the opponent's home: P1 counts up, P2 counts down.
    typedef enum logic {
        DIR_ADV = 1'b0,
        DIR_RET = 1'b1
    } dir_e;

endpackage

// File: rtl/board_game_ctrl_if.sv
// Move-request handshake and game status bundle between a player front end
// (master) and the board controller (slave).
interface board_game_ctrl_if #(
    parameter int POS_W    = 4,
    parameter int STEP_MAX = 3
);
    localparam int STEP_W = $clog2(STEP_MAX + 1);

    logic                  mv_valid;
    logic                  mv_player;
    logic                  mv_dir;
    logic                  mv_ready;
    logic [POS_W-1:0]      pos1;
    logic [POS_W-1:0]      pos2;
    logic [2**POS_W-1:0]   led;
    logic                  turn;
    logic [STEP_W-1:0]     step;
    logic                  move_done;
    logic                  blocked;
    logic                  game_over;
    logic                  winner;

    modport master (
        output mv_valid, mv_player, mv_dir,
        input  mv_ready, pos1, pos2, led, turn, step,
               move_done, blocked, game_over, winner
    );

    modport slave (
        input  mv_valid, mv_player, mv_dir,
        output mv_ready, pos1, pos2, led, turn, step,
               move_done, blocked, game_over, winner
    );

endinterface

// File: rtl/board_game_ctrl_step_seq.sv
// Step-size sequencer: climbs 1..STEP_MAX, holds the peak for one extra
// turn, descends to 0, then climbs again. Advances once per adv_i strobe.
module step_seq #(
    parameter int STEP_MAX = 3,
    localparam int STEP_W  = $clog2(STEP_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv_i,
    output logic [STEP_W-1:0] step_o
);
    localparam logic [STEP_W-1:0] STEP_TOP = STEP_W'(STEP_MAX);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    logic [STEP_W-1:0] step_q, step_d;
    logic              up_q, up_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        step_d = step_q;
        up_d   = up_q;
        if (adv_i) begin
            if (up_q) begin
                if (step_q == STEP_TOP) up_d   = 1'b0;
                else                    step_d = step_q + STEP_ONE;
            end else begin
                if (step_q == '0) begin
                    step_d = STEP_ONE;
                    up_d   = 1'b1;
                end else begin
                    step_d = step_q - STEP_ONE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= STEP_ONE;
            up_q   <= 1'b1;
        end else begin
            step_q <= step_d;
            up_q   <= up_d;
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/board_game_ctrl.sv
// Two-player board controller: accepts one move per turn, applies saturating
// position arithmetic, blocks exact-landing collisions and detects the winner.
module board_game_ctrl
    import board_pkg::*;
#(
    parameter int POS_W    = 4,
    parameter int STEP_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_game,
    board_game_ctrl_if.slave bus
);
    localparam int STEP_W = $clog2(STEP_MAX + 1);
    localparam int BMAX   = 2**POS_W - 1;
    localparam logic [POS_W-1:0] BMAX_POS = POS_W'(BMAX);
    localparam logic [POS_W:0]   BMAX_EXT = (POS_W+1)'(BMAX);

    generate
        if (STEP_MAX < 1 || STEP_MAX > BMAX) begin : g_bad_step_max
            $error("board_game_ctrl: STEP_MAX must lie in 1..2**POS_W-1");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [POS_W-1:0] pos1_q, pos1_d;
    logic [POS_W-1:0] pos2_q, pos2_d;
    player_e          turn_q, turn_d;
    dir_e             dir_q, dir_d;
    logic             move_done_q, move_done_d;
    logic             blocked_q, blocked_d;
    logic             game_over_q, game_over_d;
    logic             winner_q, winner_d;

    logic              clear;
    logic [STEP_W-1:0] step;
    logic [POS_W-1:0]  own_pos, opp_pos, target;
    logic [POS_W:0]    sum;
    logic              move_up;
    logic [2**POS_W-1:0] led;

    assign clear = rst | new_game;

    step_seq #(.STEP_MAX(STEP_MAX)) u_step (
        .clk    (clk),
        .rst    (clear),
        .adv_i  (state_q == S_MOVE),
        .step_o (step)
    );

    // Target arithmetic is one bit wider so overflow and borrow are visible
    // and can be clamped to the board edges.
    always_comb begin
        own_pos = (turn_q == P1) ? pos1_q : pos2_q;
        opp_pos = (turn_q == P1) ? pos2_q : pos1_q;
        move_up = (turn_q == P1) == (dir_q == DIR_ADV);
        sum     = '0;
        target  = own_pos;
        if (move_up) begin
            sum    = {1'b0, own_pos} + {{(POS_W+1-STEP_W){1'b0}}, step};
            target = (sum > BMAX_EXT) ? BMAX_POS : sum[POS_W-1:0];
        end else begin
            sum    = {1'b0, own_pos} - {{(POS_W+1-STEP_W){1'b0}}, step};
            target = sum[POS_W] ? '0 : sum[POS_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        pos1_d      = pos1_q;
        pos2_d      = pos2_q;
        turn_d      = turn_q;
        dir_d       = dir_q;
        move_done_d = 1'b0;
        blocked_d   = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        case (state_q)
            S_WAIT: begin
                if (bus.mv_valid && (bus.mv_player == turn_q)) begin
                    dir_d   = dir_e'(bus.mv_dir);
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                move_done_d = 1'b1;
                turn_d      = player_e'(~turn_q);
                state_d     = S_WAIT;
                if (target == opp_pos) begin
                    blocked_d = 1'b1;
                end else begin
                    if (turn_q == P1) pos1_d = target;
                    else              pos2_d = target;
                    if ((turn_q == P1 && target == BMAX_POS) ||
                        (turn_q == P2 && target == '0)) begin
                        game_over_d = 1'b1;
                        winner_d    = (turn_q == P2);
                        state_d     = S_OVER;
                    end
                end
            end
            S_OVER: ;
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= S_WAIT;
            pos1_q      <= '0;
            pos2_q      <= BMAX_POS;
            turn_q      <= P1;
            dir_q       <= DIR_ADV;
            move_done_q <= 1'b0;
            blocked_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos1_q      <= pos1_d;
            pos2_q      <= pos2_d;
            turn_q      <= turn_d;
            dir_q       <= dir_d;
            move_done_q <= move_done_d;
            blocked_q   <= blocked_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    always_comb begin
        led          = '0;
        led[pos1_q]  = 1'b1;
        led[pos2_q]  = 1'b1;
    end

    assign bus.mv_ready  = (state_q == S_WAIT);
    assign bus.pos1      = pos1_q;
    assign bus.pos2      = pos2_q;
    assign bus.led       = led;
    assign bus.turn      = turn_q;
    assign bus.step      = step;
    assign bus.move_done = move_done_q;
    assign bus.blocked   = blocked_q;
    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;

endmodule
